sop_lut_pipe: RTL
=================

// Module: sop_lut_pipe
// PURPOSE
//  Parametrised, pipelined sum-of-products evaluator: N_OUT Boolean functions of N_IN inputs, each
//  stored as a 2^N_IN-bit truth table (bit k set = minterm k present). Tables are runtime-writable.
//  Valid/ready on input and output, 2-stage pipeline with full backpressure. Used wherever fixed
//  gate-level SOP logic needs registered, reconfigurable timing.
// PARAMETERS
//  N_IN      3                      inputs per function (1..8); input index = {x[N_IN-1],...,x[0]}
//  N_OUT     1                      number of independent functions/outputs (1..8)
//  TT_INIT   {N_OUT{8'b0011_0001}}  reset truth tables, N_OUT*2^N_IN bits; function j = bits [j*2^N_IN +: 2^N_IN]
//  CNT_W     16                     width of transition counter (optional feature)
// PORTS
//  clk        in   1                 clock, rising edge
//  reset_n    in   1                 synchronous reset, active-low
//  in_valid   in   1                 input sample valid
//  in_ready   out  1                 block accepts sample this cycle
//  in_x       in   N_IN              input vector
//  out_valid  out  1                 result valid
//  out_ready  in   1                 consumer accepts result
//  out_y      out  N_OUT             function results, bit j = function j
//  cfg_we     in   1                 truth-table bit write strobe
//  cfg_fn     in   $clog2(N_OUT)+1   function select (0..N_OUT-1)
//  cfg_addr   in   N_IN              minterm index
//  cfg_data   in   1                 new truth-table bit
//  trans_cnt  out  CNT_W             out_y[0] transition count (optional feature)
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): S1/S2 valid=0, out_valid=0, out_y=0, trans_cnt=0, tables<=TT_INIT.
//    Reset mid-flight drops all in-flight samples; no output produced for them.
//  - Handshake: transfer when valid&&ready on a clock edge. out_valid/out_y stable while out_valid&&!out_ready.
//  - Pipeline: S1 registers in_x; S2 registers out_y[j]=TT[j][S1.x]. Latency exactly 2 cycles from input
//    acceptance to out_valid with out_ready held 1. Throughput 1 sample/cycle.
//  - Advance: adv2 = !out_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1 (combinational).
//    With out_ready=0 pipeline holds at most 2 samples, then in_ready=0. No sample lost or duplicated; order kept.
//  - Lookup uses table contents at the edge S1->S2 occurs. cfg write in cycle t affects samples moving
//    S1->S2 at edge t+1 or later; sample moving at edge t uses old bit.
//  - cfg_fn>=N_OUT: write ignored. cfg_we during reset: ignored.
//  - No combinational path in_x->out_y; out_ready->in_ready path allowed.
// CONFIGURATION
//  - Macro SOP_LUT_PIPE_TRANS_CNT_EN:
//    defined: trans_cnt increments by 1 on each output transfer where out_y[0] differs from out_y[0] of
//             the previous transferred result (first result after reset compared with 0); saturates at
//             2^CNT_W-1, never wraps; cleared only by reset.
//    undefined: counter logic absent, trans_cnt tied to 0.
// TESTING
//  - Reset defaults, N_IN=3,N_OUT=1: feed in_x=0..7 back-to-back, out_ready=1 -> out_y=1,0,0,0,1,1,0,0,
//    first out_valid 2 cycles after first accept, then 1 result/cycle.
//  - Backpressure: out_ready=0, feed 4 samples -> 2 accepted, in_ready=0; release -> all 4 emerge in order, no gaps lost.
//  - Reconfig: write cfg_fn=0,addr=3,data=1, then in_x=3 -> out_y=1; write addr=0,data=0, in_x=0 -> out_y=0.
//  - Reset mid-flight: 2 samples in pipe, reset_n=0 one cycle -> out_valid=0 next cycle, no stale output; table back to TT_INIT.
//  - N_OUT=2, fn1 table=8'hFF: any in_x -> out_y[1]=1; cfg_fn=2 write -> no table change.
//  - TRANS_CNT_EN defined, CNT_W=2: outputs 1,0,1,0,1 -> trans_cnt=3 (saturated); undefined -> trans_cnt=0.

Source files
------------

// File: rtl/sop_lut_pipe.sv
// sop_lut_pipe: two-stage pipelined sum-of-products evaluator with runtime-writable
// truth tables and valid/ready handshakes on both sides.
// Optional feature macro: SOP_LUT_PIPE_TRANS_CNT_EN (out_y[0] transition counter on trans_cnt).
module sop_lut_pipe #(
    parameter int unsigned                  N_IN    = 3,
    parameter int unsigned                  N_OUT   = 1,
    parameter logic [N_OUT*(2**N_IN)-1:0]   TT_INIT = {N_OUT{8'b0011_0001}},
    parameter int unsigned                  CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN-1:0]         in_x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_OUT-1:0]        out_y,
    input  logic                    cfg_we,
    input  logic [$clog2(N_OUT):0]  cfg_fn,
    input  logic [N_IN-1:0]         cfg_addr,
    input  logic                    cfg_data,
    output logic [CNT_W-1:0]        trans_cnt
);

    localparam int unsigned DEPTH = 2**N_IN;
    localparam int unsigned FN_W  = $clog2(N_OUT) + 1;
    localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    // Truth tables: r_tt[j][k] is minterm k of function j
    logic [N_OUT-1:0][DEPTH-1:0] r_tt;

    logic                   r_s1_valid;
    logic [N_IN-1:0]        r_s1_x;
    logic                   r_s2_valid;
    logic [N_OUT-1:0]       r_s2_y;

    logic                   w_adv1;
    logic                   w_adv2;
    logic                   w_fn_ok;
    logic [IDX_W-1:0]       w_fn_idx;
    logic [N_OUT-1:0]       w_lut;

    // Stage advance: S2 moves when empty or drained, S1 moves when empty or S2 moves
    always_comb begin
        w_adv2   = !r_s2_valid || out_ready;
        w_adv1   = !r_s1_valid || w_adv2;
        in_ready = w_adv1;
    end

    // Function select decode; selects at or beyond N_OUT are rejected
    always_comb begin
        w_fn_ok  = (cfg_fn < FN_W'(N_OUT));
        w_fn_idx = cfg_fn[IDX_W-1:0];
    end

    // Per-function lookup of the sample held in S1
    for (genvar g = 0; g < N_OUT; g++) begin : g_lut
        assign w_lut[g] = r_tt[g][r_s1_x];
    end

    // Table storage: reload on reset, single-bit writes otherwise
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tt <= TT_INIT;
        end else if (cfg_we && w_fn_ok) begin
            r_tt[w_fn_idx][cfg_addr] <= cfg_data;
        end
    end

    // Pipeline registers: S1 holds the input vector, S2 holds the looked-up result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_x <= in_x;
                end
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_y <= w_lut;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_y     = r_s2_y;

`ifdef SOP_LUT_PIPE_TRANS_CNT_EN
    logic             r_last_y0;
    logic [CNT_W-1:0] r_cnt;
    logic             w_out_fire;

    assign w_out_fire = r_s2_valid && out_ready;

    // Saturating count of out_y[0] changes between consecutive transferred results
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_y0 <= 1'b0;
            r_cnt     <= '0;
        end else if (w_out_fire) begin
            r_last_y0 <= r_s2_y[0];
            if ((r_s2_y[0] != r_last_y0) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign trans_cnt = r_cnt;
`else
    assign trans_cnt = '0;
`endif

endmodule
